ecall_stream_out: RTL

ECALL_STREAM_OUT -- requirements
Module: ecall_stream_out

---
 rtl/ecall_stream_out_pkg.sv | 15 +
 rtl/ecall_stream_out_fd_map.sv | 17 +
 rtl/ecall_stream_out.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ecall_stream_out_pkg.sv
// ecall_stream_out_pkg: FSM states, fd base and width defines shared by the ecall_stream_out slice.
`ifndef BIT_WIDTH
`define BIT_WIDTH 64
`endif
`ifndef MEMORY_BITS
`define MEMORY_BITS 12
`endif

package ecall_stream_out_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SEND, S_FIN} state_t;
    localparam int FD_BASE = 1;
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ecall_stream_out_fd_map.sv
// stream_fd_map: maps a file descriptor to an output channel index with a valid flag.
module stream_fd_map
    import ecall_stream_out_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int NUM_CH = 2,
    parameter int CH_W   = ch_width(NUM_CH)
) (
    input  logic [WORD_W-1:0] i_fd,
    output logic [CH_W-1:0]   o_ch,
    output logic              o_valid
);
    logic [WORD_W-1:0] w_idx;
    assign w_idx   = i_fd - WORD_W'(FD_BASE);
    assign o_valid = (i_fd >= WORD_W'(FD_BASE)) && (w_idx < WORD_W'(NUM_CH));
    assign o_ch    = w_idx[CH_W-1:0];
endmodule

// File: rtl/ecall_stream_out.sv
// ecall_stream_out: streams req_len bytes from word memory to a per-fd output channel.
// Define STREAM_TIMEOUT_EN to add a SEND stall timeout with a sticky err_timeout output.
module ecall_stream_out
    import ecall_stream_out_pkg::*;
#(
    parameter int ADDR_W = `MEMORY_BITS,
    parameter int WORD_W = `BIT_WIDTH,
    parameter int LEN_W  = 64,
    parameter int NUM_CH = 2,
    localparam int CH_W  = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [WORD_W-1:0] req_fd,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              finished,
    output logic              done_pulse,
    output logic              err_fd,
`ifdef STREAM_TIMEOUT_EN
    output logic              err_timeout,
`endif
    output logic              mem_rden,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_q,
    output logic [7:0]        out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready
);
    state_t            r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_off;
    logic [LEN_W-1:0]  w_off_nx;
    logic [CH_W-1:0]   w_ch;
    logic              w_fd_ok;
`ifdef STREAM_TIMEOUT_EN
    logic [15:0]       r_stall;
`endif

    stream_fd_map #(.WORD_W(WORD_W), .NUM_CH(NUM_CH), .CH_W(CH_W)) u_fd_map (
        .i_fd   (req_fd),
        .o_ch   (w_ch),
        .o_valid(w_fd_ok)
    );

    assign w_off_nx = r_off + 1'b1;
    assign finished = (r_state == S_FIN) || (r_state == S_IDLE && !req);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_off      <= '0;
            err_fd     <= 1'b0;
            out_valid  <= 1'b0;
            mem_rden   <= 1'b0;
            done_pulse <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            mem_addr   <= '0;
`ifdef STREAM_TIMEOUT_EN
            r_stall     <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            done_pulse <= 1'b0;
            mem_rden   <= 1'b0;
            case (r_state)
                S_IDLE: if (req) begin
                    r_len    <= req_len;
                    r_off    <= '0;
                    err_fd   <= !w_fd_ok;
                    out_ch   <= w_ch;
                    mem_addr <= req_addr[ADDR_W-1:0];
`ifdef STREAM_TIMEOUT_EN
                    err_timeout <= 1'b0;
`endif
                    if (req_len == '0 || !w_fd_ok) begin
                        r_state    <= S_FIN;
                        done_pulse <= 1'b1;
                    end else begin
                        r_state  <= S_FETCH;
                        mem_rden <= 1'b1;
                    end
                end
                S_FETCH: r_state <= S_WAIT;
                S_WAIT: begin
                    out_data  <= mem_q[7:0];
                    out_valid <= 1'b1;
                    r_state   <= S_SEND;
`ifdef STREAM_TIMEOUT_EN
                    r_stall   <= '0;
`endif
                end
                S_SEND: if (out_ready) begin
                    out_valid <= 1'b0;
                    r_off     <= w_off_nx;
                    if (w_off_nx == r_len) begin
                        r_state    <= S_FIN;
                        done_pulse <= 1'b1;
                    end else begin
                        r_state  <= S_FETCH;
                        mem_rden <= 1'b1;
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
`ifdef STREAM_TIMEOUT_EN
                else if (r_stall == 16'hFFFF) begin
                    out_valid   <= 1'b0;
                    err_timeout <= 1'b1;
                    r_state     <= S_FIN;
                    done_pulse  <= 1'b1;
                end else begin
                    r_stall <= r_stall + 1'b1;
                end
`endif
                S_FIN: if (!req) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
